// File: rtl/cache_struct_pkg.sv
// Shared types for the LLC trace intake path: request classes, command decode
// and the address-field widths of the default cache geometry.
package cache_struct_pkg;

   typedef enum logic [2:0] {
      CPU_RD = 3'd0,
      CPU_WR = 3'd1,
      SNOOP  = 3'd2,
      MAINT  = 3'd3
   } req_class_e;

   typedef struct packed {
      logic       legal;
      req_class_e cls;
   } cmd_dec_t;

   localparam int ADDR_BITS_DEF  = 32;
   localparam int LINE_BYTES_DEF = 64;
   localparam int NUM_SETS_DEF   = 16384;
   localparam int OFFSET_BITS    = $clog2(LINE_BYTES_DEF);
   localparam int SET_BITS       = $clog2(NUM_SETS_DEF);
   localparam int TAG_BITS       = ADDR_BITS_DEF - SET_BITS - OFFSET_BITS;

   localparam logic [31:0] CMD_CLEAR = 32'd8;

   function automatic cmd_dec_t cmd_decode(input logic [31:0] cmd);
      cmd_dec_t d;
      d.legal = 1'b1;
      d.cls   = CPU_RD;
      case (cmd)
         32'd0, 32'd2:               d.cls = CPU_RD;
         32'd1:                      d.cls = CPU_WR;
         32'd3, 32'd4, 32'd5, 32'd6: d.cls = SNOOP;
         32'd8, 32'd9:               d.cls = MAINT;
         default:                    d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/llc_trace_req_slicer_if.sv
// Trace-record intake and sliced-request output handshakes of the slicer.
interface llc_trace_req_slicer_if
   import cache_struct_pkg::*;
#(
   parameter int ADDR_BITS = 32,
   parameter int CMD_BITS  = 4,
   parameter int TAG_W     = 12,
   parameter int SET_W     = 14,
   parameter int OFF_W     = 6
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [CMD_BITS-1:0]  in_cmd;
   logic [ADDR_BITS-1:0] in_addr;
   logic                 out_valid;
   logic                 out_ready;
   logic [CMD_BITS-1:0]  out_cmd;
   req_class_e           out_class;
   logic [TAG_W-1:0]     out_tag;
   logic [SET_W-1:0]     out_set;
   logic [OFF_W-1:0]     out_offset;

   modport slave (
      input  in_valid, in_cmd, in_addr, out_ready,
      output in_ready, out_valid, out_cmd, out_class, out_tag, out_set, out_offset
   );

   modport master (
      output in_valid, in_cmd, in_addr, out_ready,
      input  in_ready, out_valid, out_cmd, out_class, out_tag, out_set, out_offset
   );
endinterface

// File: rtl/llc_req_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is always on dout.
module llc_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push, w_pop;

   assign w_push = push && (r_count != CW'(DEPTH));
   assign w_pop  = pop && (r_count != '0);

   // Storage is reset too so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= din;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd];
   assign count = r_count;
endmodule

// File: rtl/llc_trace_req_slicer.sv
// Trace intake: decodes/classifies commands, slices addresses into tag/set/offset,
// buffers legal requests toward the LLC controller and keeps saturating statistics.
module llc_trace_req_slicer
   import cache_struct_pkg::*;
#(
   parameter int ADDR_BITS  = 32,
   parameter int LINE_BYTES = 64,
   parameter int NUM_SETS   = 16384,
   parameter int CMD_BITS   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_BITS   = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   llc_trace_req_slicer_if.slave       bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        illegal_pulse,
   output logic [CNT_BITS-1:0]         cnt_cpu_rd,
   output logic [CNT_BITS-1:0]         cnt_cpu_wr,
   output logic [CNT_BITS-1:0]         cnt_snoop,
   output logic [CNT_BITS-1:0]         cnt_illegal
);
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_BITS - SET_W - OFF_W;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = CMD_BITS + 3 + ADDR_BITS;

   cmd_dec_t            w_dec;
   logic                w_accept, w_push, w_pop, w_clear;
   logic [CW-1:0]       w_count;
   logic [ENT_W-1:0]    w_din, w_dout;
   logic [CNT_BITS-1:0] r_cnt_rd, r_cnt_wr, r_cnt_snoop, r_cnt_ill;
   logic                r_ill;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (v == '1) ? v : v + CNT_BITS'(1);
   endfunction

   assign w_dec        = cmd_decode(32'(bus.in_cmd));
   // Ready depends only on registered occupancy, never on out_ready.
   assign bus.in_ready  = (w_count != CW'(FIFO_DEPTH));
   assign bus.out_valid = (w_count != '0);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_push        = w_accept && w_dec.legal;
   assign w_pop         = bus.out_valid && bus.out_ready;
   assign w_clear       = w_accept && (32'(bus.in_cmd) == CMD_CLEAR);
   assign w_din         = {bus.in_cmd, w_dec.cls, bus.in_addr};

   llc_req_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_din),
      .pop   (w_pop),
      .dout  (w_dout),
      .count (w_count)
   );

   assign bus.out_cmd    = w_dout[ENT_W-1 -: CMD_BITS];
   assign bus.out_class  = req_class_e'(w_dout[ADDR_BITS +: 3]);
   assign bus.out_tag    = w_dout[ADDR_BITS-1 -: TAG_W];
   assign bus.out_set    = w_dout[OFF_W +: SET_W];
   assign bus.out_offset = w_dout[OFF_W-1:0];
   assign fifo_count     = w_count;

   // Clear wins over any increment on the same accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_rd    <= '0;
         r_cnt_wr    <= '0;
         r_cnt_snoop <= '0;
         r_cnt_ill   <= '0;
         r_ill       <= 1'b0;
      end else begin
         r_ill <= w_accept && !w_dec.legal;
         if (w_clear) begin
            r_cnt_rd    <= '0;
            r_cnt_wr    <= '0;
            r_cnt_snoop <= '0;
            r_cnt_ill   <= '0;
         end else if (w_accept) begin
            if (!w_dec.legal) r_cnt_ill <= sat_inc(r_cnt_ill);
            else begin
               case (w_dec.cls)
                  CPU_RD:  r_cnt_rd    <= sat_inc(r_cnt_rd);
                  CPU_WR:  r_cnt_wr    <= sat_inc(r_cnt_wr);
                  SNOOP:   r_cnt_snoop <= sat_inc(r_cnt_snoop);
                  default: ;
               endcase
            end
         end
      end
   end

   assign illegal_pulse = r_ill;
   assign cnt_cpu_rd    = r_cnt_rd;
   assign cnt_cpu_wr    = r_cnt_wr;
   assign cnt_snoop     = r_cnt_snoop;
   assign cnt_illegal   = r_cnt_ill;
endmodule

// File: doc/llc_trace_req_slicer.md
# llc_trace_req_slicer

Parametrised intake stage between the trace-file reader and the LLC controller. Accepts raw trace records (command, physical address) on a valid/ready handshake, validates and classifies the command, and slices the address into tag/set/byte-offset for a configurable cache geometry. Results are buffered in a small FIFO toward the controller, and saturating per-class statistics counters are maintained. This is the hardware successor of the software-only address slicing and command description in the trace package.

## Interface
- ADDR_BITS, 32, physical address width
- LINE_BYTES, 64, line size in bytes (power of two); OFFSET_BITS = $clog2(LINE_BYTES)
- NUM_SETS, 16384, set count (power of two); SET_BITS = $clog2(NUM_SETS); TAG_BITS = ADDR_BITS-SET_BITS-OFFSET_BITS
- CMD_BITS, 4, trace command width
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2)
- CNT_BITS, 32, statistics counter width

Ports:
- clk  in  1  clock; everything on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid / in_ready  in / out  1  trace record handshake
- in_cmd  in  CMD_BITS  trace command code
- in_addr  in  ADDR_BITS  physical address
- out_valid / out_ready  out / in  1  sliced-request handshake
- out_cmd  out  CMD_BITS  command code, passed through
- out_class  out  3  req_class_e: CPU_RD, CPU_WR, SNOOP, MAINT
- out_tag / out_set / out_offset  out  TAG_BITS / SET_BITS / OFFSET_BITS  address fields
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- illegal_pulse  out  1  one-cycle flag when an illegal command is dropped
- cnt_cpu_rd, cnt_cpu_wr, cnt_snoop, cnt_illegal  out  CNT_BITS each  statistics

## Operation
- Legal codes and classes:
  - 0 and 2 (data and instruction read): CPU_RD.
  - 1: CPU_WR.
  - 3-6: SNOOP.
  - 8 (clear) and 9 (print): MAINT.
- Illegal codes are 7 and 10..(2^CMD_BITS-1).
- Accepted legal record: the FIFO stores {cmd, class, tag, set, offset}, split as {tag, set, offset} = in_addr. The matching class counter increments. MAINT has no counter.
- Accepted illegal record: not enqueued. illegal_pulse is asserted for the following cycle and cnt_illegal increments.
- Acceptance of cmd 8 clears all four counters to 0 on the same edge. The cmd 8 record is still enqueued so the controller flushes its state.
- All counters saturate at all-ones and never wrap.
- Output fields are valid only while out_valid=1. They show the FIFO head and hold while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, fifo_count=0, illegal_pulse=0.
  - All counters 0, all out_* fields 0.
  - FIFO pointers 0.
- Asserting rst_n low mid-operation discards buffered entries immediately, with no drain.
- Accept occurs when in_valid && in_ready at a rising edge. Pop occurs when out_valid && out_ready.
- in_ready = (fifo_count != FIFO_DEPTH), decoded from registered state, with no combinational path from out_ready.
- Latency:
  - An accepted record appears on out_valid at the next edge at the earliest. There is no same-cycle bypass.
  - Single-record throughput is one per cycle.
- Simultaneous events:
  - Push and pop on a non-empty FIFO leave fifo_count unchanged.
  - Pop from a full FIFO raises in_ready on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_count.
- An illegal record is accepted whenever in_ready=1 and does not occupy a slot. When the FIFO is full, an illegal record waits like any other.

## Structure
- cache_struct_pkg holds:
  - req_class_e.
  - The legal-command decode function.
  - The derived-width localparams for OFFSET_BITS, SET_BITS and TAG_BITS.
- The sub-module llc_req_fifo is a generic synchronous FIFO parametrised by width and depth, with count output. The top level handles decode, slicing and counters.

## Test plan
- Reset checks: with rst_n=0, in_valid=1 and out_ready=1, check all outputs hold reset values. Release, then verify in_ready=1 and out_valid=0.
- Slicing at default geometry:
  - Stimulus: cmd 0, addr 32'h1234_5678.
  - Expected: next cycle out_valid=1, out_tag=12'h123, out_set=14'h1159, out_offset=6'h38, out_class=CPU_RD, and cnt_cpu_rd=1.
- Backpressure:
  - Stimulus: out_ready=0, offer 5 legal records back-to-back.
  - Expected: 4 accepted, then in_ready=0 and fifo_count=4.
  - Then raise out_ready: records drain in order and the 5th is accepted the cycle after the first pop.
- Illegal command:
  - Stimulus: cmd 7 with FIFO empty.
  - Expected: accepted, illegal_pulse high for exactly one cycle, cnt_illegal=1, out_valid stays 0.
  - Repeat with cmd 15.
- Clear:
  - Stimulus: 3 reads and 2 snoops, then cmd 8.
  - Expected: all counters 0 after the cmd 8 accept, and cmd 8 emerges with out_class=MAINT.
  - Then: cmd 9 leaves counters at 0.
- Saturation and reset mid-operation:
  - Stimulus: with CNT_BITS=4, issue 17 writes.
  - Expected: cnt_cpu_wr=15.
  - Then: with 3 entries buffered, pulse rst_n low. Expect fifo_count=0 and out_valid=0 asynchronously, before the next edge.
